// File: rtl/fan_pkg.sv
// Shared definitions for the fan speed link: level type, bus patterns,
// temperature band lower bounds and the receive-side FSM states.
package fan_pkg;

   typedef logic [1:0] fan_lvl_t;

   localparam logic [7:0] FAN_PAT_L0 = 8'b0000_0000;
   localparam logic [7:0] FAN_PAT_L1 = 8'b0000_1111;
   localparam logic [7:0] FAN_PAT_L2 = 8'b0011_0011;
   localparam logic [7:0] FAN_PAT_L3 = 8'b1100_0011;

   localparam logic [3:0] FAN_BAND_L0 = 4'd0;
   localparam logic [3:0] FAN_BAND_L1 = 4'd3;
   localparam logic [3:0] FAN_BAND_L2 = 4'd8;
   localparam logic [3:0] FAN_BAND_L3 = 4'd12;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_SETTLE      = 2'd1,
      ST_LOCKED      = 2'd2,
      ST_LOCK_SETTLE = 2'd3
   } fan_state_t;

endpackage

// File: rtl/fan_pat_decode.sv
// Combinational lookup of a fan speed pattern into level, band lower bound
// and a legality flag; unknown patterns decode to level 0 with legal low.
module fan_pat_decode
   import fan_pkg::*;
(
   input  logic [7:0] vel_in,
   output logic [1:0] lvl,
   output logic [3:0] band,
   output logic       legal
);

   // pattern table lookup
   always_comb begin
      lvl   = 2'd0;
      band  = FAN_BAND_L0;
      legal = 1'b0;
      case (vel_in)
         FAN_PAT_L0: begin lvl = 2'd0; band = FAN_BAND_L0; legal = 1'b1; end
         FAN_PAT_L1: begin lvl = 2'd1; band = FAN_BAND_L1; legal = 1'b1; end
         FAN_PAT_L2: begin lvl = 2'd2; band = FAN_BAND_L2; legal = 1'b1; end
         FAN_PAT_L3: begin lvl = 2'd3; band = FAN_BAND_L3; legal = 1'b1; end
         default:    begin lvl = 2'd0; band = FAN_BAND_L0; legal = 1'b0; end
      endcase
   end

endmodule

// File: rtl/fan_speed_decoder.sv
// Debouncing fan speed pattern decoder with change/peak statistics.
// Define FAN_DWELL_EN to build the dwell-time counter; otherwise dwell_cnt is 0.
module fan_speed_decoder
   import fan_pkg::*;
#(
   parameter int STABLE_CYCLES = 3,
   parameter int CNT_W         = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       vel_in,
   input  logic             vel_valid,
   output logic [1:0]       level,
   output logic [3:0]       band_min,
   output logic             level_valid,
   output logic             code_err,
   output logic [CNT_W-1:0] change_cnt,
   output logic [1:0]       max_level,
   output logic [15:0]      dwell_cnt
);

   localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);

   fan_state_t       r_state;
   fan_state_t       w_state_nxt;
   fan_lvl_t         r_cand;
   fan_lvl_t         w_cand_nxt;
   logic [3:0]       r_cnt;
   logic [3:0]       w_cnt_nxt;
   logic [3:0]       w_run;
   logic             w_accept;
   logic             w_locked;
   fan_lvl_t         w_lvl;
   logic [3:0]       w_band;
   logic             w_legal;
   fan_lvl_t         r_level;
   logic [3:0]       r_band;
   logic             r_level_valid;
   logic             r_code_err;
   logic [CNT_W-1:0] r_change_cnt;
   fan_lvl_t         r_max_level;

   fan_pat_decode u_dec (
      .vel_in (vel_in),
      .lvl    (w_lvl),
      .band   (w_band),
      .legal  (w_legal)
   );

   assign w_locked = (r_state == ST_LOCKED) || (r_state == ST_LOCK_SETTLE);

   // candidate qualification and next-state selection
   always_comb begin
      w_state_nxt = r_state;
      w_cand_nxt  = r_cand;
      w_cnt_nxt   = r_cnt;
      w_run       = 4'd0;
      w_accept    = 1'b0;
      if (vel_valid) begin
         if (!w_legal) begin
            w_cand_nxt  = 2'd0;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = w_locked ? ST_LOCKED : ST_IDLE;
         end else if (w_locked && (w_lvl == r_level)) begin
            w_cand_nxt  = 2'd0;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = ST_LOCKED;
         end else begin
            // a count of zero means no candidate is pending
            if ((r_cnt != 4'd0) && (w_lvl == r_cand)) begin
               w_run = r_cnt + 4'd1;
            end else begin
               w_run = 4'd1;
            end
            if (w_run == STABLE_C) begin
               w_accept    = 1'b1;
               w_cand_nxt  = 2'd0;
               w_cnt_nxt   = 4'd0;
               w_state_nxt = ST_LOCKED;
            end else begin
               w_cand_nxt  = w_lvl;
               w_cnt_nxt   = w_run;
               w_state_nxt = w_locked ? ST_LOCK_SETTLE : ST_SETTLE;
            end
         end
      end else begin
         w_state_nxt = r_state;
      end
   end

   // state, candidate and accepted-level registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_cand        <= 2'd0;
         r_cnt         <= 4'd0;
         r_level       <= 2'd0;
         r_band        <= 4'd0;
         r_level_valid <= 1'b0;
         r_code_err    <= 1'b0;
         r_change_cnt  <= '0;
         r_max_level   <= 2'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_cand     <= w_cand_nxt;
         r_cnt      <= w_cnt_nxt;
         r_code_err <= vel_valid & ~w_legal;
         if (w_accept) begin
            r_level       <= w_lvl;
            r_band        <= w_band;
            r_level_valid <= 1'b1;
            if (w_lvl > r_max_level) begin
               r_max_level <= w_lvl;
            end
            if (r_level_valid && (w_lvl != r_level) && (r_change_cnt != {CNT_W{1'b1}})) begin
               r_change_cnt <= r_change_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
      end
   end

`ifdef FAN_DWELL_EN
   logic [15:0] r_dwell;

   // cycles since last acceptance, saturating
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dwell <= 16'd0;
      end else if (w_accept || !r_level_valid) begin
         r_dwell <= 16'd0;
      end else if (r_dwell != 16'hFFFF) begin
         r_dwell <= r_dwell + 16'd1;
      end
   end

   assign dwell_cnt = r_dwell;
`else
   assign dwell_cnt = 16'd0;
`endif

   assign level       = r_level;
   assign band_min    = r_band;
   assign level_valid = r_level_valid;
   assign code_err    = r_code_err;
   assign change_cnt  = r_change_cnt;
   assign max_level   = r_max_level;

endmodule

// File: doc/fan_speed_decoder.md
Name: fan_speed_decoder

Overview:
- Receive-side counterpart of the temperature-to-fan-speed encoder.
- Samples the 8-bit fan speed pattern bus and recovers the speed level (0..3) and the lower bound of the temperature band that produced it.
- Debounces the pattern over several clock cycles and flags illegal codes.
- Keeps change and peak-level statistics for the fan monitoring logic.

Parameters:
- STABLE_CYCLES, 3, consecutive valid identical samples required before a new level is accepted (legal range 1..15).
- CNT_W, 8, width of the level-change counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- vel_in  input  8  fan speed pattern.
- vel_valid  input  1  vel_in is meaningful this cycle.
- level  output  2  accepted speed level.
- band_min  output  4  minimum temperature of the accepted level: 0, 3, 8 or 12.
- level_valid  output  1  high once any level has been accepted.
- code_err  output  1  one-cycle pulse on an illegal sampled pattern.
- change_cnt  output  CNT_W  number of accepted level changes.
- max_level  output  2  highest level accepted since reset.
- dwell_cnt  output  16  cycles spent in the current level; see Optional Feature.

Behaviour:
- Legal codes:
  - 8'b00000000 -> level 0, band_min 0
  - 8'b00001111 -> level 1, band_min 3
  - 8'b00110011 -> level 2, band_min 8
  - 8'b11000011 -> level 3, band_min 12
  - Any other value is illegal.
- Reset (rst=1 at an edge):
  - level=0, band_min=0, level_valid=0, code_err=0, change_cnt=0, max_level=0, dwell_cnt=0.
  - Candidate register and stability counter are cleared; FSM goes to IDLE.
  - Reset mid-settle discards the candidate.
- FSM states:
  - IDLE: nothing accepted yet.
  - SETTLE: qualifying a candidate code.
  - LOCKED: a level is accepted, no candidate pending.
  - LOCK_SETTLE: a level is accepted and a different candidate is being qualified.
- vel_valid=0: the sample is ignored; candidate, stability counter and state all hold. Gaps do not break a stable run.
- Legal sample with vel_valid=1:
  - Sample equals the candidate: stability count increments.
  - Sample differs from the candidate: it becomes the new candidate with count=1.
  - In LOCKED, a sample equal to the accepted level is not a candidate: count is cleared and the state stays LOCKED.
  - LOCK_SETTLE returns to LOCKED the same way when a sample matches the accepted level.
- Acceptance:
  - Occurs at the edge where the count reaches STABLE_CYCLES.
  - level, band_min and level_valid update at that edge and are visible the following cycle.
  - With STABLE_CYCLES=1 this is one cycle after the sample.
- On acceptance:
  - max_level <= max(max_level, new level).
  - change_cnt increments only if previously locked and the new level differs from the old one.
  - change_cnt saturates at all ones; it does not wrap.
  - State goes to LOCKED.
- Illegal sample with vel_valid=1:
  - code_err=1 for exactly the next cycle; consecutive illegal samples give consecutive pulses.
  - Candidate and count are cleared.
  - SETTLE -> IDLE; LOCK_SETTLE -> LOCKED.
  - Accepted outputs are never altered by an illegal code.
- Simultaneous rst and any input: reset wins.

Optional Feature:
- Macro: FAN_DWELL_EN.
- Defined:
  - dwell_cnt counts clock cycles since the last acceptance, saturating at 16'hFFFF.
  - Cleared to 0 at every acceptance, including re-acceptance of the same level from IDLE.
  - Held at 0 while level_valid=0.
- Not defined:
  - dwell_cnt is tied to 0.
  - No counter logic is synthesised.
  - The port remains, so the interface is identical in both builds.

Decomposition:
- Package fan_pkg holds:
  - Level typedef (2 bits).
  - Pattern constants FAN_PAT_L0..FAN_PAT_L3.
  - Band constants FAN_BAND_L0..FAN_BAND_L3 (0, 3, 8, 12).
  - FSM state enum.
- The encoder side is updated to use the same pattern constants.
- One combinational sub-module, fan_pat_decode: inputs vel_in; outputs lvl[1:0], band[3:0] and legal. The FSM and counters stay in fan_speed_decoder.

Test Plan (STABLE_CYCLES=3, FAN_DWELL_EN defined unless stated):
- Reset, then hold vel_in=8'b00001111, vel_valid=1 for 3 cycles -> on the 4th cycle level=1, band_min=3, level_valid=1, change_cnt=0, max_level=1.
- From level 1, drive 8'b11000011 for 2 cycles then 8'b00001111 -> no change; drive 8'b11000011 for 3 cycles -> level=3, band_min=12, change_cnt=1, max_level=3.
- While locked at level 3, drive 8'b10101010 for 1 cycle -> code_err pulses for exactly 1 cycle; level stays 3; change_cnt is unchanged.
- Drive 8'b00110011 with vel_valid pattern 1,0,0,1,1 -> acceptance after the third valid sample; level=2, band_min=8, max_level stays 3.
- Assert rst while in SETTLE with count=2 -> all outputs return to 0; the next 3 valid samples of 8'b00000000 lock level 0 with change_cnt=0.
- Lock level 1, wait 10 cycles -> dwell_cnt=10. Rebuild without FAN_DWELL_EN -> dwell_cnt stays 0 throughout.
